// File: rtl/an_encoder_13.sv
// Sequential AN-code encoder: computes ANe = A*N by shift-and-add over AW steps,
// with an optional single-bit error flip, behind a valid/ready handshake on each side.
module an_encoder_13 #(
  parameter int unsigned A   = 13,
  parameter int unsigned AW  = 4,
  parameter int unsigned NW  = 8,
  parameter int unsigned ANW = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NW-1:0]  N,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           inj_en,
  input  logic [3:0]     inj_pos,
  output logic [ANW-1:0] ANe,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [15:0]    word_cnt
);

  localparam int unsigned   KW     = (AW > 1) ? $clog2(AW) : 1;
  localparam logic [AW-1:0] A_BITS = AW'(A);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [NW-1:0]  mcand, mcand_nxt;
  logic [ANW-1:0] acc, acc_nxt;
  logic [KW-1:0]  k, k_nxt;
  logic           inj_en_l, inj_en_nxt;
  logic [3:0]     inj_pos_l, inj_pos_nxt;
  logic           in_ready_nxt, out_valid_nxt;
  logic [ANW-1:0] ane_nxt, flip_c;
  logic [15:0]    word_cnt_nxt;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mcand     <= '0;
      acc       <= '0;
      k         <= '0;
      inj_en_l  <= 1'b0;
      inj_pos_l <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ANe       <= '0;
      word_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      mcand     <= mcand_nxt;
      acc       <= acc_nxt;
      k         <= k_nxt;
      inj_en_l  <= inj_en_nxt;
      inj_pos_l <= inj_pos_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      ANe       <= ane_nxt;
      word_cnt  <= word_cnt_nxt;
    end
  end

  // Next state plus the shift-and-add datapath
  always_comb begin
    state_nxt   = state;
    mcand_nxt   = mcand;
    acc_nxt     = acc;
    k_nxt       = k;
    inj_en_nxt  = inj_en_l;
    inj_pos_nxt = inj_pos_l;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          mcand_nxt   = N;
          inj_en_nxt  = inj_en;
          inj_pos_nxt = inj_pos;
          acc_nxt     = '0;
          k_nxt       = '0;
          state_nxt   = CALC;
        end
      end
      CALC: begin
        if (A_BITS[k]) begin
          acc_nxt = acc + (ANW'(mcand) << k);
        end
        k_nxt = k + KW'(1);
        if (k == KW'(AW - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output values for the coming cycle; positions beyond the code word flip nothing
  always_comb begin
    flip_c        = '0;
    in_ready_nxt  = (state_nxt == IDLE);
    out_valid_nxt = (state_nxt == DONE);
    word_cnt_nxt  = word_cnt;
    if (inj_en_l && (32'(inj_pos_l) < ANW)) begin
      flip_c = ANW'(1) << inj_pos_l;
    end
    ane_nxt = (state_nxt == DONE) ? (acc_nxt ^ flip_c) : '0;
    if ((state == DONE) && out_ready && (word_cnt != 16'hFFFF)) begin
      word_cnt_nxt = word_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_an_encoder_13.sv
// Self-checking bench for an_encoder_13: directed vector table, back-pressure,
// asynchronous reset mid-word, a full back-to-back stream and random words.
module tb_an_encoder_13;

  localparam int unsigned A   = 13;
  localparam int unsigned AW  = 4;
  localparam int unsigned NW  = 8;
  localparam int unsigned ANW = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic [NW-1:0]  N;
  logic           in_valid;
  logic           in_ready;
  logic           inj_en;
  logic [3:0]     inj_pos;
  logic [ANW-1:0] ANe;
  logic           out_valid;
  logic           out_ready;
  logic [15:0]    word_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  an_encoder_13 #(.A(A), .AW(AW), .NW(NW), .ANW(ANW)) dut (
    .clk(clk), .rst(rst), .N(N), .in_valid(in_valid), .in_ready(in_ready),
    .inj_en(inj_en), .inj_pos(inj_pos), .ANe(ANe), .out_valid(out_valid),
    .out_ready(out_ready), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NW-1:0]  n;
    logic           en;
    logic [3:0]     pos;
    logic [ANW-1:0] exp_ane;
  } vec_t;

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  function automatic logic [ANW-1:0] model(input int n, input bit en, input int pos);
    int v;
    v = A * n;
    if (en && pos < ANW) v = v ^ (1 << pos);
    return ANW'(v);
  endfunction

  // Present one word; returns at the negedge after the accepting edge
  task automatic send(input logic [NW-1:0] n, input logic en, input logic [3:0] pos);
    @(negedge clk);
    chk("ready_before_send", in_ready, 1);
    N = n; inj_en = en; inj_pos = pos; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ready_low_in_calc", in_ready, 0);
    chk("ane_zero_in_calc", ANe, 0);
  endtask

  // Wait for the result, hold it under back-pressure, then complete the handshake
  task automatic drain(input string name, input logic [ANW-1:0] exp, input int hold);
    int lat;
    lat = 0;
    out_ready = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk({name, "_latency"}, lat, AW);
    chk({name, "_ane"}, ANe, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, out_valid, 1);
      chk({name, "_hold_ready"}, in_ready, 0);
      chk({name, "_hold_ane"}, ANe, exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    if (exp_cnt < 16'hFFFF) exp_cnt++;
    chk({name, "_valid_drop"}, out_valid, 0);
    chk({name, "_idle_ready"}, in_ready, 1);
    chk({name, "_word_cnt"}, word_cnt, exp_cnt);
  endtask

  initial begin
    vec_t vecs[8];
    int q[$];
    int accepted, got, last_acc, cyc, e;
    bit acc_now;
    logic [NW-1:0] rn;
    logic          ren;
    logic [3:0]    rpos;

    vecs[0] = '{8'd0,   1'b0, 4'd0,  12'h000};
    vecs[1] = '{8'd255, 1'b0, 4'd0,  12'hCF3};
    vecs[2] = '{8'd19,  1'b0, 4'd0,  12'h0F7};
    vecs[3] = '{8'd10,  1'b1, 4'd3,  12'h08A};
    vecs[4] = '{8'd10,  1'b1, 4'd12, 12'h082};
    vecs[5] = '{8'd10,  1'b1, 4'd15, 12'h082};
    vecs[6] = '{8'd1,   1'b1, 4'd11, 12'h80D};
    vecs[7] = '{8'd200, 1'b0, 4'd0,  12'hA28};

    rst = 1'b1; N = '0; in_valid = 1'b0; inj_en = 1'b0; inj_pos = '0; out_ready = 1'b0;
    #12;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_ane", ANe, 0);
    chk("reset_word_cnt", word_cnt, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].n, vecs[i].en, vecs[i].pos);
      drain($sformatf("vec%0d", i), vecs[i].exp_ane, 0);
    end

    // Long back-pressure
    send(8'd19, 1'b0, 4'd0);
    drain("backpressure", 12'h0F7, 10);

    // Asynchronous reset two edges into a word, then accept on the first edge after release
    send(8'd100, 1'b0, 4'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_word_cnt", word_cnt, 0);
    chk("async_rst_ane", ANe, 0);
    exp_cnt = 0;
    @(negedge clk);
    N = 8'd1; inj_en = 1'b0; inj_pos = '0; in_valid = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    chk("post_rst_accept", in_ready, 0);
    drain("post_rst", 12'h00D, 0);

    // Back-to-back stream N=0..255; accepts are AW+2 edges apart (AW+1 edges in between)
    inj_en = 1'b0;
    accepted = 0; got = 0; last_acc = -1; cyc = 0;
    @(negedge clk);
    N = '0; in_valid = 1'b1; out_ready = 1'b1;
    while (got < 256 && cyc < 256 * 8) begin
      acc_now = 1'b0;
      if (out_valid) begin
        if (q.size() > 0) e = q.pop_front(); else e = -1;
        chk($sformatf("stream_ane_n%0d", got), ANe, e);
        chk($sformatf("stream_mod_n%0d", got), ANe % A, 0);
        got++;
      end
      if (in_ready && in_valid) begin
        if (last_acc >= 0) chk($sformatf("stream_interval_%0d", accepted), cyc - last_acc, AW + 2);
        last_acc = cyc;
        q.push_back(A * int'(N));
        accepted++;
        acc_now = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (acc_now) begin
        N = NW'(accepted);
        in_valid = (accepted < 256);
      end
    end
    chk("stream_count", got, 256);
    in_valid = 1'b0; out_ready = 1'b0;
    exp_cnt += got;
    @(negedge clk);
    chk("stream_word_cnt", word_cnt, exp_cnt);

    // Random words against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rn   = NW'($urandom_range(0, 255));
      ren  = 1'($urandom_range(0, 1));
      rpos = 4'($urandom_range(0, 15));
      send(rn, ren, rpos);
      drain($sformatf("rand%0d", i), model(int'(rn), ren, int'(rpos)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
